// File: rtl/vector_result_pipeline.sv
// Four-stage holding pipeline for vector results between execute and register-file commit.
// Exposes every stage as a bypass source and retires the oldest entry to the register file.
module vector_result_pipeline #(
    parameter int REG_IDX_WIDTH = 7,
    parameter int VECTOR_LANES  = 16,
    parameter int LANE_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic                               result_valid_i,
    input  logic [REG_IDX_WIDTH-1:0]           result_register_i,
    input  logic [VECTOR_LANES-1:0]            result_mask_i,
    input  logic [VECTOR_LANES*LANE_WIDTH-1:0] result_value_i,
    output logic [REG_IDX_WIDTH-1:0]           bypass1_register_o,
    output logic                               bypass1_write_o,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0] bypass1_value_o,
    output logic [VECTOR_LANES-1:0]            bypass1_mask_o,
    output logic [REG_IDX_WIDTH-1:0]           bypass2_register_o,
    output logic                               bypass2_write_o,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0] bypass2_value_o,
    output logic [VECTOR_LANES-1:0]            bypass2_mask_o,
    output logic [REG_IDX_WIDTH-1:0]           bypass3_register_o,
    output logic                               bypass3_write_o,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0] bypass3_value_o,
    output logic [VECTOR_LANES-1:0]            bypass3_mask_o,
    output logic [REG_IDX_WIDTH-1:0]           bypass4_register_o,
    output logic                               bypass4_write_o,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0] bypass4_value_o,
    output logic [VECTOR_LANES-1:0]            bypass4_mask_o,
    output logic                               rf_write_en_o,
    output logic [REG_IDX_WIDTH-1:0]           rf_write_reg_o,
    output logic [VECTOR_LANES-1:0]            rf_write_mask_o,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0] rf_write_value_o,
    output logic [31:0]                        commit_count_o
);

    localparam int VALUE_WIDTH = VECTOR_LANES * LANE_WIDTH;

    logic [3:0]               valid_q;
    logic [REG_IDX_WIDTH-1:0] reg_q   [4];
    logic [VECTOR_LANES-1:0]  mask_q  [4];
    logic [VALUE_WIDTH-1:0]   value_q [4];
    logic [31:0]              commit_count_q;

    // Flush kills the two youngest stages and the incoming result; stage3 picks up
    // a killed stage2 entry, so only the older two stages keep their valids.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                reg_q[i]   <= '0;
                mask_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (!stall_i) begin
            valid_q[0] <= result_valid_i & ~flush_i;
            valid_q[1] <= valid_q[0] & ~flush_i;
            valid_q[2] <= valid_q[1] & ~flush_i;
            valid_q[3] <= valid_q[2];
            reg_q[0]   <= result_register_i;
            mask_q[0]  <= result_mask_i;
            value_q[0] <= result_value_i;
            for (int i = 1; i < 4; i++) begin
                reg_q[i]   <= reg_q[i-1];
                mask_q[i]  <= mask_q[i-1];
                value_q[i] <= value_q[i-1];
            end
        end else if (flush_i) begin
            valid_q[0] <= 1'b0;
            valid_q[1] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count_q <= '0;
        end else if (rf_write_en_o) begin
            commit_count_q <= commit_count_q + 32'd1;
        end
    end

    assign bypass1_register_o = reg_q[0];
    assign bypass1_write_o    = valid_q[0] & (|mask_q[0]);
    assign bypass1_value_o    = value_q[0];
    assign bypass1_mask_o     = mask_q[0];
    assign bypass2_register_o = reg_q[1];
    assign bypass2_write_o    = valid_q[1] & (|mask_q[1]);
    assign bypass2_value_o    = value_q[1];
    assign bypass2_mask_o     = mask_q[1];
    assign bypass3_register_o = reg_q[2];
    assign bypass3_write_o    = valid_q[2] & (|mask_q[2]);
    assign bypass3_value_o    = value_q[2];
    assign bypass3_mask_o     = mask_q[2];
    assign bypass4_register_o = reg_q[3];
    assign bypass4_write_o    = valid_q[3] & (|mask_q[3]);
    assign bypass4_value_o    = value_q[3];
    assign bypass4_mask_o     = mask_q[3];

    // Commit is gated by stall in the same cycle so a held entry retires only once.
    assign rf_write_en_o    = valid_q[3] & (|mask_q[3]) & ~stall_i;
    assign rf_write_reg_o   = reg_q[3];
    assign rf_write_mask_o  = mask_q[3];
    assign rf_write_value_o = value_q[3];
    assign commit_count_o   = commit_count_q;

endmodule

// File: doc/vector_result_pipeline.md
Name: vector_result_pipeline

Overview:
- Holds vector results for four cycles between execute and register-file commit.
- Drives the four bypass source ports (register, write, value, lane mask) of the downstream vector bypass unit.
- Bypass port 1 is the youngest entry and has the highest priority; port 4 is the oldest.
- Retires the oldest entry to the vector register file write port and counts committed writes.

Parameters:
- REG_IDX_WIDTH, 7, width of a vector register index.
- VECTOR_LANES, 16, number of 32-bit lanes per vector.
- LANE_WIDTH, 32, bits per lane.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hold every stage; no advance, no commit
- flush_i  in  1  squash stages 1-2 and the incoming result
- result_valid_i  in  1  execute stage presents a vector result
- result_register_i  in  REG_IDX_WIDTH  destination register
- result_mask_i  in  VECTOR_LANES  per-lane write enables
- result_value_i  in  VECTOR_LANES*LANE_WIDTH  result data
- bypassN_register_o  out  REG_IDX_WIDTH  stage N destination (N=1..4)
- bypassN_write_o  out  1  stage N valid and mask nonzero
- bypassN_value_o  out  VECTOR_LANES*LANE_WIDTH  stage N data
- bypassN_mask_o  out  VECTOR_LANES  stage N lane mask
- rf_write_en_o  out  1  commit strobe to the register file
- rf_write_reg_o  out  REG_IDX_WIDTH  commit register
- rf_write_mask_o  out  VECTOR_LANES  commit lane mask
- rf_write_value_o  out  VECTOR_LANES*LANE_WIDTH  commit data
- commit_count_o  out  32  number of committed writes, wraps modulo 2^32

Behaviour:
- Storage: four stage registers (valid, register, mask, value).
- Reset: all valids clear; all register, mask and value fields and commit_count_o go to 0; every output is 0 while reset is asserted and after it deasserts.
- Advance (stall_i=0, flush_i=0), per rising edge:
  - stage1 <= input, with valid = result_valid_i.
  - stage2 <= stage1; stage3 <= stage2; stage4 <= stage3.
  - The stage4 contents are consumed.
- Latency: a result accepted at edge T appears on bypass1 after T, bypass2 after T+1, bypass3 after T+2 and bypass4 after T+3. It is committed during the cycle after T+3.
- Bypass outputs are combinational from the stage registers.
- bypassN_write_o = validN & (maskN != 0).
- Register, value and mask outputs show the stage contents even when the stage is invalid; consumers qualify them with the write bit.
- Commit output:
  - rf_write_en_o = valid4 & (mask4 != 0) & ~stall_i. This is combinational, so each entry commits exactly once, during the cycle it leaves stage4.
  - rf_write_reg_o, rf_write_mask_o and rf_write_value_o mirror stage4 at all times.
- commit_count_o increments at each edge where rf_write_en_o was high.
- Stall (stall_i=1, flush_i=0):
  - All stages hold and the input is ignored.
  - No commit occurs and the counter holds.
  - The upstream stage must re-present the result until it is accepted.
- Flush (flush_i=1):
  - stage1 and stage2 valids clear at the edge, and the incoming result is dropped.
  - If stall_i=0: stage3 <= old stage2 contents, but the flush clears their valid before they land, so stage3 becomes invalid. Stage4 <= old stage3, and the old stage4 commits normally.
  - If stall_i=1: stages 3 and 4 hold, and no commit occurs.
  - Flush always wins over stall for stages 1-2.
- Zero-mask entry:
  - It propagates with valid set.
  - Its write bit is 0 at every stage, it produces no commit, and it does not increment the counter.
- Same register in several stages: each stage is presented independently; priority resolution is the consumer's responsibility.
- Reset mid-operation: every in-flight entry is discarded without being committed, and the counter returns to 0.

Test Plan:
- Single result: reg 5, mask 16'hFFFF, lane i = i, accepted at edge 0.
  - bypass1_write_o=1 after edge 0 and bypass4_write_o=1 after edge 3.
  - rf_write_en_o=1 for exactly one cycle after edge 3; commit_count_o=1.
- Back-to-back results, reg 3 with mask 16'h00FF then reg 3 with mask 16'hFF00.
  - The second entry is on bypass1 while the first is on bypass2, with correct masks.
  - Two commits occur in order; commit_count_o=2.
- Stall for 3 cycles while an entry is in stage4.
  - rf_write_en_o=0 throughout the stall and the outputs are frozen.
  - The entry commits once on the cycle stall_i drops.
- Flush with entries A (stage1), B (stage2), C (stage3), D (stage4), and input E valid.
  - D commits; next cycle stage4=C and stages 1-3 are invalid.
  - A, B and E never commit.
- Zero mask: result with mask 16'h0000 and valid=1.
  - All bypassN_write_o stay 0, there is no commit, and the counter is unchanged.
- Reset asserted with 4 valid entries.
  - All outputs go to 0 asynchronously, nothing commits after release, and commit_count_o=0.
